writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Single-writer front end for the integer register file write port (wr_en/wr_addr/wr_data).
- Merges two result sources onto the one write port:
  - Port A: in-order pipeline results (ALU/branch-link), has priority.
  - Port B: long-latency results (load/mul-div), valid/ready, buffered in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on registers whose long-latency result has not yet been written.

Parameters:
- WIDTH, 32, data width of register values.
- FIFO_DEPTH, 2, port-B result buffer entries (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may be blocked by port A before port A is back-pressured (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk)
- a_valid  in  1  port-A result valid
- a_ready  out  1  port-A accepted this cycle
- a_rd  in  5  port-A destination register
- a_data  in  WIDTH  port-A result
- b_valid  in  1  port-B result valid
- b_ready  out  1  port-B FIFO can accept
- b_rd  in  5  port-B destination register
- b_data  in  WIDTH  port-B result
- iss_en  in  1  long-latency op issued; mark iss_rd pending
- iss_rd  in  5  destination of issued long-latency op
- rs1_addr  in  5  scoreboard query 1
- rs1_busy  out  1  rs1_addr has a pending long-latency write
- rs2_addr  in  5  scoreboard query 2
- rs2_busy  out  1  rs2_addr has a pending long-latency write
- wr_en  out  1  register file write enable
- wr_addr  out  5  register file write address
- wr_data  out  WIDTH  register file write data
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy of port-B FIFO

Behaviour:
- Reset (reset==0 at posedge):
  - wr_en=0, wr_addr=0, wr_data=0.
  - FIFO empty, fifo_count=0.
  - All scoreboard bits clear; starve counter=0.
  - Reset mid-operation discards buffered results and pending bits.
- Handshakes:
  - b_ready = (fifo_count < FIFO_DEPTH); combinational from registered state only.
  - a_ready = (starve_cnt != STARVE_LIMIT).
  - A transfer = a_valid & a_ready; B transfer = b_valid & b_ready.
- Write-port selection, evaluated each cycle, result registered (latency 1 to wr_*):
  - 1. A transfer -> wr_en<=1, wr_addr<=a_rd, wr_data<=a_data.
  - 2. Else FIFO non-empty -> pop head onto wr_*.
  - 3. Else B transfer with FIFO empty -> bypass: b_rd/b_data go to wr_* directly, not enqueued.
  - 4. Else wr_en<=0; wr_addr/wr_data hold.
- B results not bypassed are enqueued; push and pop in the same cycle are allowed when full.
- Starve counter:
  - Increments when FIFO non-empty and no pop this cycle.
  - Resets to 0 on any pop, or when FIFO empty.
  - Saturates at STARVE_LIMIT.
  - At limit: a_ready=0 and the head is popped that cycle.
- x0 handling:
  - A transfer with a_rd==0 still occupies the write slot but drives wr_en<=0.
  - B transfer with b_rd==0 is accepted and dropped (not enqueued, no write, no scoreboard effect).
  - iss_en with iss_rd==0 is ignored.
- Scoreboard, busy bits [31:1]:
  - Set on iss_en.
  - Cleared when a B result for that rd is driven to wr_* (pop or bypass).
  - Same-cycle set and clear on the same rd: set wins.
  - rsN_busy = busy[rsN_addr], combinational; always 0 for address 0.
  - A writes do not touch busy bits.
- Ordering:
  - B results are written in arrival order.
  - A and B are not reordered against each other beyond the priority rules above.

Decomposition:
- Shared package holds:
  - REG_FIELD_RANGE / REG_RANGE constants.
  - A wb_entry_t struct {rd[4:0], data[WIDTH-1:0]}.
- One sub-module, wb_result_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty/count.
- Arbitration, starve counter and scoreboard stay in the top level.

Test Plan:
- Reset: hold reset=0 two cycles after random traffic -> wr_en=0, fifo_count=0, rs1_busy=rs2_busy=0, b_ready=1.
- Bypass: idle, iss_en rd=5; next cycle b_valid rd=5 data=0xDEADBEEF -> next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; rs1_busy for addr 5 is 1 before the write and 0 after.
- Priority/buffer: same cycle a_valid rd=3 data=0x11, b_valid rd=7 data=0x22 -> cycle+1 writes x3=0x11, fifo_count=1; cycle+2 writes x7=0x22.
- Full: a_valid held 1, three b_valid pushes with FIFO_DEPTH=2 -> b_ready=0 after two, third push waits.
- Starvation: a_valid held 1 with FIFO non-empty -> after STARVE_LIMIT=4 blocked cycles a_ready=0 for exactly one cycle and the head is written.
- x0: b_valid rd=0 data=0x55 -> accepted, no wr_en, fifo_count unchanged. Also iss_en rd=9 and B clear of rd=9 in the same cycle -> busy[9] remains 1.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// wb_entry_t describes one buffered long-latency result.
package writeback_arbiter_pkg;

   localparam int REG_FIELD_RANGE = 5;
   localparam int REG_RANGE       = 32;
   localparam int WB_WIDTH        = 32;

   typedef struct packed {
      logic [REG_FIELD_RANGE-1:0] rd;
      logic [WB_WIDTH-1:0]        data;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering long-latency results until the write port is free.
// The caller guarantees no push while full unless a pop happens in the same cycle.
module wb_result_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = wb_entry_t
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  T                         i_pushEntry,
   input  logic                     i_pop,
   output T                         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T                r_mem [DEPTH];
   logic [AW-1:0]   r_rdPtr;
   logic [AW-1:0]   r_wrPtr;
   logic [CW-1:0]   r_count;

   // Storage is not reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wrPtr] <= i_pushEntry;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (i_push && !i_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!i_push && i_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_head  = r_mem[r_rdPtr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges in-order (port A) and long-latency (port B) results onto the single
// register-file write port and tracks pending long-latency destinations.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          a_valid,
   output logic                          a_ready,
   input  logic [REG_FIELD_RANGE-1:0]    a_rd,
   input  logic [WIDTH-1:0]              a_data,
   input  logic                          b_valid,
   output logic                          b_ready,
   input  logic [REG_FIELD_RANGE-1:0]    b_rd,
   input  logic [WIDTH-1:0]              b_data,
   input  logic                          iss_en,
   input  logic [REG_FIELD_RANGE-1:0]    iss_rd,
   input  logic [REG_FIELD_RANGE-1:0]    rs1_addr,
   output logic                          rs1_busy,
   input  logic [REG_FIELD_RANGE-1:0]    rs2_addr,
   output logic                          rs2_busy,
   output logic                          wr_en,
   output logic [REG_FIELD_RANGE-1:0]    wr_addr,
   output logic [WIDTH-1:0]              wr_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [REG_FIELD_RANGE-1:0] rd;
      logic [WIDTH-1:0]           data;
   } entry_t;

   logic [SW-1:0]                r_starveCnt;
   logic [REG_RANGE-1:0]         r_busy;
   logic [REG_RANGE-1:0]         w_busyNext;
   logic                         w_full;
   logic                         w_empty;
   logic                         w_aXfer;
   logic                         w_bXfer;
   logic                         w_pop;
   logic                         w_bypass;
   logic                         w_push;
   logic                         w_clrEn;
   logic [REG_FIELD_RANGE-1:0]   w_clrRd;
   entry_t                       w_head;
   entry_t                       w_pushEntry;

   assign a_ready  = (r_starveCnt != SW'(STARVE_LIMIT));
   assign b_ready  = !w_full;
   assign w_aXfer  = a_valid && a_ready;
   assign w_bXfer  = b_valid && b_ready;
   // The head drains whenever A does not claim the slot; at the starve limit A is held off.
   assign w_pop    = !w_aXfer && !w_empty;
   assign w_bypass = !w_aXfer && w_empty && w_bXfer && (b_rd != '0);
   assign w_push   = w_bXfer && (b_rd != '0) && !w_bypass;

   assign w_pushEntry = '{rd: b_rd, data: b_data};
   assign w_clrEn     = w_pop || w_bypass;
   assign w_clrRd     = w_pop ? w_head.rd : b_rd;

   wb_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_pushEntry (w_pushEntry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (fifo_count)
   );

   // A new issue to the same register outranks the completing write.
   always_comb begin
      w_busyNext = r_busy;
      if (w_clrEn) begin
         w_busyNext[w_clrRd] = 1'b0;
      end
      if (iss_en && (iss_rd != '0)) begin
         w_busyNext[iss_rd] = 1'b1;
      end
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         r_starveCnt <= '0;
         r_busy      <= '0;
      end else begin
         r_busy <= w_busyNext;
         if (w_aXfer) begin
            wr_en <= (a_rd != '0);
            if (a_rd != '0) begin
               wr_addr <= a_rd;
               wr_data <= a_data;
            end
         end else if (w_pop) begin
            wr_en   <= 1'b1;
            wr_addr <= w_head.rd;
            wr_data <= w_head.data;
         end else if (w_bypass) begin
            wr_en   <= 1'b1;
            wr_addr <= b_rd;
            wr_data <= b_data;
         end else begin
            wr_en <= 1'b0;
         end
         if (w_empty || w_pop) begin
            r_starveCnt <= '0;
         end else if (r_starveCnt != SW'(STARVE_LIMIT)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
         end
      end
   end

   assign rs1_busy = r_busy[rs1_addr];
   assign rs2_busy = r_busy[rs2_addr];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based
// reference model of the arbitration, starvation and scoreboard rules.
module tb_writeback_arbiter;

   localparam int WIDTH        = 32;
   localparam int FIFO_DEPTH   = 2;
   localparam int STARVE_LIMIT = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         a_valid, a_ready, b_valid, b_ready;
   logic [4:0]   a_rd, b_rd, iss_rd, rs1_addr, rs2_addr, wr_addr;
   logic [31:0]  a_data, b_data, wr_data;
   logic         iss_en, rs1_busy, rs2_busy, wr_en;
   logic [1:0]   fifo_count;

   ent_t         mq[$];
   int           mStarve;
   bit           mBusy [32];
   logic         mWrEn;
   logic [4:0]   mWrAddr;
   logic [31:0]  mWrData;
   bit           modelValid = 1'b0;

   int           nCompared   = 0;
   int           nMismatched = 0;

   writeback_arbiter #(
      .WIDTH        (WIDTH),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_rd       (a_rd),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_rd       (b_rd),
      .b_data     (b_data),
      .iss_en     (iss_en),
      .iss_rd     (iss_rd),
      .rs1_addr   (rs1_addr),
      .rs1_busy   (rs1_busy),
      .rs2_addr   (rs2_addr),
      .rs2_busy   (rs2_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock: drive inputs, compare against the model, advance the model, cross the edge.
   task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                                input logic ie, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
      bit   aRdy, bRdy, aX, bX, wasEmpty, bypassed, clr;
      logic [4:0] clrRd;
      ent_t e;
      reset = rst; a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      iss_en = ie; iss_rd = ird; rs1_addr = r1; rs2_addr = r2;
      #1;
      aRdy = (mStarve != STARVE_LIMIT);
      bRdy = (mq.size() < FIFO_DEPTH);
      if (modelValid) begin
         checkOutput("aReady", a_ready, aRdy);
         checkOutput("bReady", b_ready, bRdy);
         checkOutput("fifoCount", fifo_count, mq.size());
         checkOutput("rs1Busy", rs1_busy, mBusy[r1]);
         checkOutput("rs2Busy", rs2_busy, mBusy[r2]);
         checkOutput("wrEn", wr_en, mWrEn);
         if (mWrEn) begin
            checkOutput("wrAddr", wr_addr, mWrAddr);
            checkOutput("wrData", wr_data, mWrData);
         end
      end
      if (!rst) begin
         mq.delete();
         mStarve = 0;
         foreach (mBusy[i]) mBusy[i] = 1'b0;
         mWrEn = 1'b0; mWrAddr = '0; mWrData = '0;
         modelValid = 1'b1;
      end else begin
         aX = av && aRdy;
         bX = bv && bRdy;
         wasEmpty = (mq.size() == 0);
         bypassed = 1'b0;
         clr = 1'b0;
         clrRd = '0;
         if (aX) begin
            mWrEn = (ard != 0);
            if (ard != 0) begin mWrAddr = ard; mWrData = ad; end
         end else if (!wasEmpty) begin
            e = mq.pop_front();
            mWrEn = 1'b1; mWrAddr = e.rd; mWrData = e.data;
            clr = 1'b1; clrRd = e.rd;
         end else if (bX && brd != 0) begin
            mWrEn = 1'b1; mWrAddr = brd; mWrData = bd;
            bypassed = 1'b1; clr = 1'b1; clrRd = brd;
         end else begin
            mWrEn = 1'b0;
         end
         if (bX && brd != 0 && !bypassed) mq.push_back('{rd: brd, data: bd});
         if (wasEmpty || clr && !bypassed) mStarve = 0;
         else if (mStarve < STARVE_LIMIT) mStarve++;
         if (clr) mBusy[clrRd] = 1'b0;
         if (ie && ird != 0) mBusy[ird] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
      iss_en = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Bypass with scoreboard set then clear
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
      checkOutput("bypassBusyBefore", rs1_busy, 1);
      applyStimulus(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
      checkOutput("bypassWrEn", wr_en, 1);
      checkOutput("bypassWrAddr", wr_addr, 5);
      checkOutput("bypassWrData", wr_data, 32'hDEADBEEF);
      checkOutput("bypassBusyAfter", rs1_busy, 0);

      // A has priority, B is buffered then drained
      applyStimulus(1, 1, 3, 32'h11, 1, 7, 32'h22, 0, 0, 0, 0);
      checkOutput("prioWrAddr", wr_addr, 3);
      checkOutput("prioWrData", wr_data, 32'h11);
      checkOutput("prioCount", fifo_count, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("drainWrAddr", wr_addr, 7);
      checkOutput("drainWrData", wr_data, 32'h22);
      checkOutput("drainCount", fifo_count, 0);

      // Full FIFO back-pressure and starvation release
      applyStimulus(1, 1, 10, 32'h100, 1, 11, 32'hB11, 0, 0, 0, 0);
      applyStimulus(1, 1, 10, 32'h101, 1, 12, 32'hB12, 0, 0, 0, 0);
      checkOutput("fullCount", fifo_count, 2);
      checkOutput("fullBReady", b_ready, 0);
      applyStimulus(1, 1, 10, 32'h102, 1, 13, 32'hB13, 0, 0, 0, 0);
      applyStimulus(1, 1, 10, 32'h103, 1, 13, 32'hB13, 0, 0, 0, 0);
      checkOutput("starveAReadyHigh", a_ready, 1);
      applyStimulus(1, 1, 10, 32'h104, 1, 13, 32'hB13, 0, 0, 0, 0);
      checkOutput("starveAReadyLow", a_ready, 0);
      applyStimulus(1, 1, 10, 32'h105, 1, 13, 32'hB13, 0, 0, 0, 0);
      checkOutput("starveWrAddr", wr_addr, 11);
      checkOutput("starveWrData", wr_data, 32'hB11);
      checkOutput("starveAReadyBack", a_ready, 1);
      checkOutput("starveCount", fifo_count, 1);
      applyStimulus(1, 1, 10, 32'h106, 1, 13, 32'hB13, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("starveDrained", fifo_count, 0);

      // x0 drop and same-cycle set/clear
      applyStimulus(1, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0);
      checkOutput("x0WrEn", wr_en, 0);
      checkOutput("x0Count", fifo_count, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      applyStimulus(1, 0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0);
      checkOutput("setWinsBusy", rs1_busy, 1);
      checkOutput("setWinsWrAddr", wr_addr, 9);

      // Random traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom_range(0, 199) != 0),
                       ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                       ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                       ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      // Reset after busy traffic
      for (int n = 0; n < 40; n++) begin
         applyStimulus(1, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom,
                       1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 20, 20, 21);
      applyStimulus(0, 1, 4, 32'h44, 1, 6, 32'h66, 1, 21, 20, 21);
      applyStimulus(0, 1, 4, 32'h44, 1, 6, 32'h66, 1, 21, 20, 21);
      checkOutput("resetWrEn", wr_en, 0);
      checkOutput("resetWrAddr", wr_addr, 0);
      checkOutput("resetWrData", wr_data, 0);
      checkOutput("resetCount", fifo_count, 0);
      checkOutput("resetRs1Busy", rs1_busy, 0);
      checkOutput("resetRs2Busy", rs2_busy, 0);
      checkOutput("resetBReady", b_ready, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
